synth_slot_sched: RTL and testbench

SYNTH_SLOT_SCHED -- requirements
Module: synth_slot_sched

---
 rtl/synth_pkg.sv | 26 ++
 rtl/synth_slot_sched_if.sv | 59 +++++
 rtl/sync_edge_det.sv | 38 +++
 rtl/synth_slot_sched.sv | 151 +++++++++++++++
 tb/tb_synth_slot_sched.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/synth_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg
// Shared definitions for the synth slot scheduler: FSM state encoding, default
// frame geometry (voices, oscillators and envelopes per voice) and a width
// helper used to size index ports.
// -----------------------------------------------------------------------------
package synth_pkg;

  localparam int VOICES_DEF = 8;
  localparam int V_OSC_DEF  = 4;
  localparam int V_ENVS_DEF = 2 * V_OSC_DEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OSC_RUN = 2'd1,
    ENV_RUN = 2'd2,
    DONE    = 2'd3
  } sched_state_e;

  // Index width for a count of n items; never narrower than one bit so a
  // degenerate single-slot configuration still has a legal port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/synth_slot_sched_if.sv
// -----------------------------------------------------------------------------
// synth_slot_sched_if
// Slot-request bus between the scheduler (master) and the oscillator/envelope
// datapaths plus status consumer (slave).
//   osc_valid/osc_ready, osc_voice, osc_idx : oscillator slot handshake
//   env_valid/env_ready, env_voice, env_idx : envelope slot handshake
//   frame_busy, frame_done                  : frame status
//   overrun, overrun_clr                    : sticky overrun flag and its clear
//   overrun_cnt                             : overrun event count, present only
//                                             when SCHED_OVERRUN_CNT_EN is defined
// -----------------------------------------------------------------------------
interface synth_slot_sched_if
  import synth_pkg::*;
#(
  parameter int VOICES = VOICES_DEF,
  parameter int V_OSC  = V_OSC_DEF,
  parameter int V_ENVS = 2 * V_OSC
);
  localparam int VW = idx_w(VOICES);
  localparam int OW = idx_w(V_OSC);
  localparam int EW = idx_w(V_ENVS);

  logic          osc_valid;
  logic          osc_ready;
  logic [VW-1:0] osc_voice;
  logic [OW-1:0] osc_idx;
  logic          env_valid;
  logic          env_ready;
  logic [VW-1:0] env_voice;
  logic [EW-1:0] env_idx;
  logic          frame_busy;
  logic          frame_done;
  logic          overrun;
  logic          overrun_clr;
`ifdef SCHED_OVERRUN_CNT_EN
  logic [7:0]    overrun_cnt;
`endif

  modport master (
    input  osc_ready, env_ready, overrun_clr,
    output osc_valid, osc_voice, osc_idx,
    output env_valid, env_voice, env_idx,
`ifdef SCHED_OVERRUN_CNT_EN
    output overrun_cnt,
`endif
    output frame_busy, frame_done, overrun
  );

  modport slave (
    output osc_ready, env_ready, overrun_clr,
    input  osc_valid, osc_voice, osc_idx,
    input  env_valid, env_voice, env_idx,
`ifdef SCHED_OVERRUN_CNT_EN
    input  overrun_cnt,
`endif
    input  frame_busy, frame_done, overrun
  );

endinterface

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Two-flop synchronizer followed by a registered rising-edge detector.
// rise_o pulses for exactly one clk cycle, three cycles after async_i rises;
// falling edges produce nothing.
//   clk     : destination clock
//   rst_n   : asynchronous active-low reset
//   async_i : signal from a foreign clock domain
//   rise_o  : one-cycle rising-edge pulse
// -----------------------------------------------------------------------------
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);
  logic meta_q, sync_q, prev_q, rise_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the
  // synchronizer chain into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/synth_slot_sched.sv
// -----------------------------------------------------------------------------
// synth_slot_sched
// Per-frame slot sequencer for a voice synthesizer. Each rising edge of the
// sample word clock starts a frame: every oscillator slot is requested
// (index-inner, voice-outer), then every envelope slot, then frame_done
// pulses. Slots advance on valid/ready handshakes. A frame start arriving
// while a frame is still in flight is dropped and flagged as overrun.
//   OSC_CLK     : oscillator-rate clock (rising edge)
//   reset_reg_N : asynchronous active-low reset
//   LRCK_1X     : sample-rate word clock, asynchronous to OSC_CLK
//   bus         : synth_slot_sched_if master (slot handshakes and status)
// Optional: define SCHED_OVERRUN_CNT_EN to add the saturating 8-bit
// overrun_cnt event counter.
// -----------------------------------------------------------------------------
module synth_slot_sched
  import synth_pkg::*;
#(
  parameter int VOICES = VOICES_DEF,
  parameter int V_OSC  = V_OSC_DEF,
  parameter int V_ENVS = 2 * V_OSC
) (
  input  logic               OSC_CLK,
  input  logic               reset_reg_N,
  input  logic               LRCK_1X,
  synth_slot_sched_if.master bus
);
  localparam int VW = idx_w(VOICES);
  localparam int OW = idx_w(V_OSC);
  localparam int EW = idx_w(V_ENVS);
  localparam int IW = (OW > EW) ? OW : EW;

  localparam logic [VW-1:0] LAST_VOICE = VW'(VOICES - 1);
  localparam logic [IW-1:0] LAST_OSC   = IW'(V_OSC - 1);
  localparam logic [IW-1:0] LAST_ENV   = IW'(V_ENVS - 1);

  sched_state_e  state_q, state_d;
  logic [VW-1:0] voice_q, voice_d;
  logic [IW-1:0] idx_q, idx_d;   // shared by both phases; only one runs at a time
  logic          overrun_q;
  logic          frame_start, drop;
  logic          osc_valid, env_valid, frame_done, xfer, last_idx;

  sync_edge_det u_sync (
    .clk     (OSC_CLK),
    .rst_n   (reset_reg_N),
    .async_i (LRCK_1X),
    .rise_o  (frame_start)
  );

  assign drop = frame_start && (state_q != IDLE);

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    voice_d    = voice_q;
    idx_d      = idx_q;
    osc_valid  = 1'b0;
    env_valid  = 1'b0;
    frame_done = 1'b0;
    xfer       = 1'b0;
    last_idx   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = OSC_RUN;
          voice_d = '0;
          idx_d   = '0;
        end
      end
      OSC_RUN: begin
        osc_valid = 1'b1;
        xfer      = bus.osc_ready;
        last_idx  = (idx_q == LAST_OSC);
      end
      ENV_RUN: begin
        env_valid = 1'b1;
        xfer      = bus.env_ready;
        last_idx  = (idx_q == LAST_ENV);
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Index wraps only at the end of a voice row; the voice counter wraps only
    // after the last row, which is also the phase boundary.
    if (xfer) begin
      if (!last_idx) begin
        idx_d = idx_q + IW'(1);
      end else begin
        idx_d = '0;
        if (voice_q != LAST_VOICE) begin
          voice_d = voice_q + VW'(1);
        end else begin
          voice_d = '0;
          state_d = (state_q == OSC_RUN) ? ENV_RUN : DONE;
        end
      end
    end
  end

  always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q <= IDLE;
      voice_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      voice_q <= voice_d;
      idx_q   <= idx_d;
    end
  end

  // A dropped start sets the flag even if a clear arrives in the same cycle.
  always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N)         overrun_q <= 1'b0;
    else if (drop)            overrun_q <= 1'b1;
    else if (bus.overrun_clr) overrun_q <= 1'b0;
  end

`ifdef SCHED_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt_q;

  always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      overrun_cnt_q <= '0;
    end else if (drop) begin
      if (overrun_cnt_q != 8'hFF) overrun_cnt_q <= overrun_cnt_q + 8'd1;
    end else if (bus.overrun_clr) begin
      overrun_cnt_q <= '0;
    end
  end

  assign bus.overrun_cnt = overrun_cnt_q;
`endif

  // Indices read as zero whenever their phase is not requesting a slot.
  assign bus.osc_valid  = osc_valid;
  assign bus.osc_voice  = osc_valid ? voice_q : '0;
  assign bus.osc_idx    = osc_valid ? idx_q[OW-1:0] : '0;
  assign bus.env_valid  = env_valid;
  assign bus.env_voice  = env_valid ? voice_q : '0;
  assign bus.env_idx    = env_valid ? idx_q[EW-1:0] : '0;
  assign bus.frame_busy = (state_q != IDLE);
  assign bus.frame_done = frame_done;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_synth_slot_sched.sv
// -----------------------------------------------------------------------------
// tb_synth_slot_sched
// Self-checking bench for synth_slot_sched. A frame-position model (slot
// number within the frame, derived from the sampled word clock) predicts every
// output each cycle; directed sections pin frame length, stall behaviour,
// overrun handling, mid-frame reset and counter saturation with literal values.
// Build with SCHED_OVERRUN_CNT_EN defined to also check overrun_cnt.
// -----------------------------------------------------------------------------
module tb_synth_slot_sched;
  import synth_pkg::*;

  localparam int VOICES = 8;
  localparam int V_OSC  = 4;
  localparam int V_ENVS = 8;
  localparam int N_OSC  = VOICES * V_OSC;
  localparam int N_ENV  = VOICES * V_ENVS;
  localparam int N_TOT  = N_OSC + N_ENV;   // model position N_TOT means DONE

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic lrck  = 1'b0;

  synth_slot_sched_if #(.VOICES(VOICES), .V_OSC(V_OSC), .V_ENVS(V_ENVS)) bus ();

  synth_slot_sched #(.VOICES(VOICES), .V_OSC(V_OSC), .V_ENVS(V_ENVS)) dut (
    .OSC_CLK     (clk),
    .reset_reg_N (rst_n),
    .LRCK_1X     (lrck),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_pos: -1 idle, 0..N_OSC-1 oscillator slot, N_OSC..N_TOT-1 envelope slot,
  // N_TOT done cycle. m_hist holds the last four word-clock samples, newest in
  // bit 0; a frame start is visible three cycles after the sampled rise.
  int         m_pos  = -1;
  logic [3:0] m_hist = '0;
  logic       m_ovr  = 1'b0;
  int         m_cnt  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos  <= -1;
      m_hist <= '0;
      m_ovr  <= 1'b0;
      m_cnt  <= 0;
    end else begin
      logic fs;
      int   np;
      fs = m_hist[2] & ~m_hist[3];
      np = m_pos;
      if (m_pos == -1) begin
        if (fs) np = 0;
      end else if (m_pos == N_TOT) begin
        np = -1;
      end else if ((m_pos < N_OSC) ? bus.osc_ready : bus.env_ready) begin
        np = m_pos + 1;
      end
      m_pos  <= np;
      m_hist <= {m_hist[2:0], lrck};
      if (fs && m_pos != -1) begin
        m_ovr <= 1'b1;
        if (m_cnt < 255) m_cnt <= m_cnt + 1;
      end else if (bus.overrun_clr) begin
        m_ovr <= 1'b0;
        m_cnt <= 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int   p, q;
    logic ov, ev;
    p  = m_pos;
    q  = p - N_OSC;
    ov = (p >= 0) && (p < N_OSC);
    ev = (p >= N_OSC) && (p < N_TOT);
    check("osc_valid", 32'(bus.osc_valid), 32'(ov));
    check("osc_voice", 32'(bus.osc_voice), ov ? p / V_OSC : 0);
    check("osc_idx", 32'(bus.osc_idx), ov ? p % V_OSC : 0);
    check("env_valid", 32'(bus.env_valid), 32'(ev));
    check("env_voice", 32'(bus.env_voice), ev ? q / V_ENVS : 0);
    check("env_idx", 32'(bus.env_idx), ev ? q % V_ENVS : 0);
    check("frame_busy", 32'(bus.frame_busy), 32'(p != -1));
    check("frame_done", 32'(bus.frame_done), 32'(p == N_TOT));
    check("overrun", 32'(bus.overrun), 32'(m_ovr));
    check("valid_exclusive", 32'(bus.osc_valid & bus.env_valid), 0);
`ifdef SCHED_OVERRUN_CNT_EN
    check("overrun_cnt", 32'(bus.overrun_cnt), m_cnt);
`endif
  end

  // ---------------- event tallies (sampled at the edge) ----------------
  int n_osc_x = 0, n_env_x = 0, n_done = 0, n_busy = 0;
  always @(posedge clk) begin
    if (bus.osc_valid && bus.osc_ready) n_osc_x <= n_osc_x + 1;
    if (bus.env_valid && bus.env_ready) n_env_x <= n_env_x + 1;
    if (bus.frame_done)                 n_done  <= n_done + 1;
    if (bus.frame_busy)                 n_busy  <= n_busy + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 2000 && bus.frame_busy; i++) @(negedge clk);
    check(name, 32'(bus.frame_busy), 0);
  endtask

  task automatic wait_osc_slot(input string name, input int v, input int k);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (bus.osc_valid && bus.osc_voice == 3'(v) && bus.osc_idx == 2'(k)) break;
    end
    check(name, 32'(i < 300), 1);
  endtask

  initial begin
    int ox0, ex0, dn0, bz0, lat, tgl;
    bus.osc_ready   = 1'b1;
    bus.env_ready   = 1'b1;
    bus.overrun_clr = 1'b0;

    // Reset state
    #3;
    check("rst_osc_valid", 32'(bus.osc_valid), 0);
    check("rst_env_valid", 32'(bus.env_valid), 0);
    check("rst_busy", 32'(bus.frame_busy), 0);
    check("rst_overrun", 32'(bus.overrun), 0);
    step(3);
    rst_n = 1'b1;
    step(2);

    // Full frame with both readies high
    ox0 = n_osc_x; ex0 = n_env_x; dn0 = n_done; bz0 = n_busy;
    lrck = 1'b1;
    lat  = 0;
    for (int i = 0; i < 20 && !bus.osc_valid; i++) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check("start_latency", lat, 4);
    check("first_osc_voice", 32'(bus.osc_voice), 0);
    check("first_osc_idx", 32'(bus.osc_idx), 0);
    wait_idle("frame_timeout");
    step(1);
    check("osc_transfers", n_osc_x - ox0, 32);
    check("env_transfers", n_env_x - ex0, 64);
    check("frame_done_count", n_done - dn0, 1);
    check("busy_cycles", n_busy - bz0, 97);
    lrck = 1'b0;
    step(6);

    // Stall osc_ready for 5 cycles at (v2,i3)
    lrck = 1'b1;
    wait_osc_slot("reach_v2i3", 2, 3);
    bus.osc_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("stall_voice", 32'(bus.osc_voice), 2);
      check("stall_idx", 32'(bus.osc_idx), 3);
    end
    bus.osc_ready = 1'b1;
    @(negedge clk);
    #1;
    check("after_stall_voice", 32'(bus.osc_voice), 3);
    check("after_stall_idx", 32'(bus.osc_idx), 0);
    lrck = 1'b0;
    wait_idle("stall_frame_timeout");
    step(4);

    // Overrun during ENV_RUN, explicit clear, then clear colliding with a drop
    lrck = 1'b1;
    for (int i = 0; i < 200 && !bus.env_valid; i++) @(negedge clk);
    check("reach_env_run", 32'(bus.env_valid), 1);
    step(1);
    lrck = 1'b0;
    step(4);
    lrck = 1'b1;
    step(6);
    check("overrun_set", 32'(bus.overrun), 1);
    check("frame_continues", 32'(bus.env_valid), 1);
`ifdef SCHED_OVERRUN_CNT_EN
    check("overrun_cnt_one", 32'(bus.overrun_cnt), 1);
`endif
    lrck = 1'b0;
    step(4);
    bus.overrun_clr = 1'b1;
    step(1);
    bus.overrun_clr = 1'b0;
    step(1);
    check("overrun_cleared", 32'(bus.overrun), 0);
    lrck = 1'b1;
    step(3);
    bus.overrun_clr = 1'b1;
    step(1);
    bus.overrun_clr = 1'b0;
    step(2);
    check("set_beats_clear", 32'(bus.overrun), 1);
`ifdef SCHED_OVERRUN_CNT_EN
    check("inc_beats_clear", 32'(bus.overrun_cnt), 1);
`endif
    lrck = 1'b0;
    wait_idle("overrun_frame_timeout");
    bus.overrun_clr = 1'b1;
    step(1);
    bus.overrun_clr = 1'b0;
    step(2);

    // Randomized readies, clears and word-clock timing against the model
    tgl = $urandom_range(1, 150);
    repeat (4000) begin
      bus.osc_ready   = ($urandom_range(0, 3) != 0);
      bus.env_ready   = ($urandom_range(0, 3) != 0);
      bus.overrun_clr = ($urandom_range(0, 15) == 0);
      tgl--;
      if (tgl == 0) begin
        lrck = ~lrck;
        tgl  = $urandom_range(1, 150);
      end
      step(1);
    end
    bus.osc_ready   = 1'b1;
    bus.env_ready   = 1'b1;
    bus.overrun_clr = 1'b0;
    lrck            = 1'b0;
    step(6);
    wait_idle("random_drain_timeout");
    step(2);

    // Reset mid-frame at (v4,i1), then restart
    lrck = 1'b1;
    wait_osc_slot("reach_v4i1", 4, 1);
    dn0   = n_done;
    rst_n = 1'b0;
    #1;
    check("abort_osc_valid", 32'(bus.osc_valid), 0);
    check("abort_osc_voice", 32'(bus.osc_voice), 0);
    check("abort_osc_idx", 32'(bus.osc_idx), 0);
    check("abort_busy", 32'(bus.frame_busy), 0);
    check("abort_overrun", 32'(bus.overrun), 0);
    lrck = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(4);
    check("no_done_after_abort", n_done - dn0, 0);
    lrck = 1'b1;
    for (int i = 0; i < 20 && !bus.osc_valid; i++) @(negedge clk);
    check("restart_valid", 32'(bus.osc_valid), 1);
    check("restart_voice", 32'(bus.osc_voice), 0);
    check("restart_idx", 32'(bus.osc_idx), 0);
    lrck = 1'b0;
    wait_idle("restart_frame_timeout");
    step(4);

    // Frame held busy while the word clock keeps rising: counter saturates
    bus.osc_ready = 1'b0;
    lrck = 1'b1;
    step(8);
    repeat (300) begin
      lrck = 1'b0;
      step(4);
      lrck = 1'b1;
      step(4);
    end
    step(6);
    check("held_busy", 32'(bus.frame_busy), 1);
    check("held_overrun", 32'(bus.overrun), 1);
`ifdef SCHED_OVERRUN_CNT_EN
    check("overrun_cnt_saturated", 32'(bus.overrun_cnt), 255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
